// File: rtl/ram_burst_reader.sv
// Streams a burst of consecutive RAM words over a valid/ready interface.
// It hides the one-cycle RAM read latency and downstream stalls behind a 2-entry buffer.
module ram_burst_reader #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 11,
  parameter int LEN_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [LEN_BITS-1:0]  len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] r_addr,
  input  logic [WIDTH-1:0]     r_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] ONE_A = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic [LEN_BITS-1:0]  ONE_L = {{(LEN_BITS-1){1'b0}}, 1'b1};

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] r_addr_next;
  logic [LEN_BITS-1:0]  len_r, len_next;
  logic [LEN_BITS-1:0]  issued, issued_next;
  logic                 inflight, inflight_last;
  logic                 issue, issue_last, pop, room;
  logic [1:0]           occ;
  logic [WIDTH-1:0]     data0, data1;
  logic                 last0, last1;

  assign pop       = (occ != 2'd0) & out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = data0;
  assign out_last  = out_valid & last0;
  assign busy      = (state == S_READ) | (state == S_DRAIN);
  assign done      = (state == S_DONE);

  // Buffered words plus the word in flight, minus the one leaving now, must stay below 2.
  assign room = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  // Next-state, address and issue decision
  always_comb begin
    state_next  = state;
    r_addr_next = r_addr;
    len_next    = len_r;
    issued_next = issued;
    issue       = 1'b0;
    issue_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          r_addr_next = base_addr;
          len_next    = len;
          issued_next = '0;
          state_next  = (len == '0) ? S_DONE : S_READ;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_READ: begin
        if (room) begin
          issue       = 1'b1;
          issued_next = issued + ONE_L;
          if ((issued + ONE_L) == len_r) begin
            issue_last = 1'b1;
            state_next = S_DRAIN;
          end else begin
            r_addr_next = r_addr + ONE_A;
          end
        end else begin
          state_next = S_READ;
        end
      end
      S_DRAIN: begin
        if (pop && last0) begin
          state_next = S_DONE;
        end else begin
          state_next = S_DRAIN;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      r_addr        <= '0;
      len_r         <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_next;
      r_addr        <= r_addr_next;
      len_r         <= len_next;
      issued        <= issued_next;
      inflight      <= issue;
      inflight_last <= issue_last;
    end
  end

  // Two-entry buffer, head in data0; captures the word read at the previous edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      case ({inflight, pop})
        2'b11: begin
          if (occ == 2'd1) begin
            data0 <= r_data;
            last0 <= inflight_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= r_data;
            last1 <= inflight_last;
          end
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          occ   <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            data0 <= r_data;
            last0 <= inflight_last;
          end else begin
            data1 <= r_data;
            last1 <= inflight_last;
          end
          occ <= occ + 2'd1;
        end
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: cycle tables for latency/wrap/empty bursts,
// plus streamed bursts with stalls, ignored starts and an asynchronous mid-burst reset.
module tb_ram_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] len;
  logic        busy, done;
  logic [10:0] r_addr;
  logic [63:0] r_data;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;

  logic [63:0] mem [0:2047];
  int nvec = 0;
  int nmis = 0;

  ram_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .r_addr(r_addr), .r_data(r_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) r_data <= mem[r_addr];

  typedef struct {
    logic        start;
    logic [10:0] base;
    logic [11:0] len;
    logic        ready;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic        exp_last;
    logic        exp_busy;
    logic        exp_done;
    logic [10:0] exp_raddr;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  function automatic vec_t mkv(logic s, logic [10:0] b, logic [11:0] l, logic v,
                               logic [63:0] d, logic la, logic bu, logic dn, logic [10:0] ra);
    vec_t x;
    x.start = s; x.base = b; x.len = l; x.ready = 1'b1;
    x.exp_valid = v; x.exp_data = d; x.exp_last = la;
    x.exp_busy = bu; x.exp_done = dn; x.exp_raddr = ra;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] word_at(input logic [10:0] b, input int idx);
    logic [10:0] a;
    a = b + 11'(idx);
    return 64'(a) * 64'd3;
  endfunction

  // mode 0: ready held 1; mode 1: ready 1,0,1,0...; mode 2: ready 0 for 10 cycles from stall_at
  task automatic run_burst(input logic [10:0] b, input logic [11:0] n, input int mode,
                           input int stall_at, input logic poke);
    int idx, cyc, acc_at_stall;
    logic rdy, hold_pending, held_last, v_s, l_s;
    logic [63:0] held, d_s;
    @(negedge clk);
    start = 1'b1; base_addr = b; len = n; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; idx = 0; hold_pending = 1'b0; acc_at_stall = 0;
    held = '0; held_last = 1'b0;
    while (!done && cyc < 200) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 2 == 0);
      else                rdy = !(cyc >= stall_at && cyc < stall_at + 10);
      if (poke && cyc == 2) begin
        start = 1'b1; base_addr = 11'd500; len = 12'd3;
      end else begin
        start = 1'b0;
      end
      if (hold_pending) begin
        chk($sformatf("b%0d_stall_valid", b), out_valid, 1'b1);
        chk($sformatf("b%0d_stall_data", b), out_data, held);
        chk($sformatf("b%0d_stall_last", b), out_last, held_last);
      end
      if (mode == 2 && cyc == stall_at) acc_at_stall = idx;
      if (mode == 2 && (cyc == stall_at + 5 || cyc == stall_at + 9)) begin
        chk($sformatf("b%0d_frozen_raddr", b), r_addr, b + 11'(acc_at_stall + 2));
        chk($sformatf("b%0d_frozen_valid", b), out_valid, 1'b1);
      end
      out_ready = rdy;
      v_s = out_valid; d_s = out_data; l_s = out_last;
      @(posedge clk);
      if (v_s && rdy) begin
        chk($sformatf("b%0d_word%0d", b, idx), d_s, word_at(b, idx));
        chk($sformatf("b%0d_last%0d", b, idx), l_s, (idx == int'(n) - 1));
        idx++;
      end
      hold_pending = v_s && !rdy;
      held = d_s; held_last = l_s;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk($sformatf("b%0d_done_seen", b), done, 1'b1);
    chk($sformatf("b%0d_count", b), idx, n);
    chk($sformatf("b%0d_busy_at_done", b), busy, 1'b0);
    chk($sformatf("b%0d_valid_at_done", b), out_valid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 64'(i) * 64'd3;

    // base=5 len=4: first word two edges after start, done one cycle after last
    vt[0]  = mkv(1'b1, 11'd5,    12'd4, 1'b0, 64'd0,    1'b0, 1'b1, 1'b0, 11'd5);
    vt[1]  = mkv(1'b0, 11'd0,    12'd0, 1'b0, 64'd0,    1'b0, 1'b1, 1'b0, 11'd6);
    vt[2]  = mkv(1'b0, 11'd0,    12'd0, 1'b1, 64'd15,   1'b0, 1'b1, 1'b0, 11'd7);
    vt[3]  = mkv(1'b0, 11'd0,    12'd0, 1'b1, 64'd18,   1'b0, 1'b1, 1'b0, 11'd8);
    vt[4]  = mkv(1'b0, 11'd0,    12'd0, 1'b1, 64'd21,   1'b0, 1'b1, 1'b0, 11'd8);
    vt[5]  = mkv(1'b0, 11'd0,    12'd0, 1'b1, 64'd24,   1'b1, 1'b1, 1'b0, 11'd8);
    vt[6]  = mkv(1'b0, 11'd0,    12'd0, 1'b0, 64'd0,    1'b0, 1'b0, 1'b1, 11'd8);
    vt[7]  = mkv(1'b0, 11'd0,    12'd0, 1'b0, 64'd0,    1'b0, 1'b0, 1'b0, 11'd8);
    // base=2046 len=4: address wraps
    vt[8]  = mkv(1'b1, 11'd2046, 12'd4, 1'b0, 64'd0,    1'b0, 1'b1, 1'b0, 11'd2046);
    vt[9]  = mkv(1'b0, 11'd0,    12'd0, 1'b0, 64'd0,    1'b0, 1'b1, 1'b0, 11'd2047);
    vt[10] = mkv(1'b0, 11'd0,    12'd0, 1'b1, 64'd6138, 1'b0, 1'b1, 1'b0, 11'd0);
    vt[11] = mkv(1'b0, 11'd0,    12'd0, 1'b1, 64'd6141, 1'b0, 1'b1, 1'b0, 11'd1);
    vt[12] = mkv(1'b0, 11'd0,    12'd0, 1'b1, 64'd0,    1'b0, 1'b1, 1'b0, 11'd1);
    vt[13] = mkv(1'b0, 11'd0,    12'd0, 1'b1, 64'd3,    1'b1, 1'b1, 1'b0, 11'd1);
    vt[14] = mkv(1'b0, 11'd0,    12'd0, 1'b0, 64'd0,    1'b0, 1'b0, 1'b1, 11'd1);
    vt[15] = mkv(1'b0, 11'd0,    12'd0, 1'b0, 64'd0,    1'b0, 1'b0, 1'b0, 11'd1);
    // len=0: done right away, busy never high
    vt[16] = mkv(1'b1, 11'd9,    12'd0, 1'b0, 64'd0,    1'b0, 1'b0, 1'b1, 11'd9);
    vt[17] = mkv(1'b0, 11'd0,    12'd0, 1'b0, 64'd0,    1'b0, 1'b0, 1'b0, 11'd9);

    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_raddr", r_addr, 11'd0);
    chk("rst_data", out_data, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      start = vt[k].start; base_addr = vt[k].base; len = vt[k].len; out_ready = vt[k].ready;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", k), out_valid, vt[k].exp_valid);
      if (vt[k].exp_valid) begin
        chk($sformatf("vec%0d_data", k), out_data, vt[k].exp_data);
      end
      chk($sformatf("vec%0d_last", k), out_last, vt[k].exp_last);
      chk($sformatf("vec%0d_busy", k), busy, vt[k].exp_busy);
      chk($sformatf("vec%0d_done", k), done, vt[k].exp_done);
      chk($sformatf("vec%0d_raddr", k), r_addr, vt[k].exp_raddr);
    end
    start = 1'b0;

    run_burst(11'd0,   12'd6, 1, 0, 1'b0);
    run_burst(11'd10,  12'd8, 2, 3, 1'b0);
    run_burst(11'd100, 12'd8, 0, 0, 1'b1);

    // asynchronous reset in the middle of a burst
    @(negedge clk);
    start = 1'b1; base_addr = 11'd20; len = 12'd5; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_last", out_last, 1'b0);
    chk("arst_data", out_data, 64'd0);
    chk("arst_raddr", r_addr, 11'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    run_burst(11'd7, 12'd2, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
